// File: rtl/eco32_core_lsu_dcu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : eco32_core_lsu_dcu_pkg
//  Description : Shared definitions for the LSU data-cache unit: descriptor
//                field positions, miss-handler state encoding, line geometry.
//  Revision    : 1.0  initial release
// ============================================================================
package eco32_core_lsu_dcu_pkg;

    localparam int LINE_OFS_W  = 6;
    localparam int DESC_W      = 39;

    // Descriptor field positions
    localparam int ASID_LSB    = 32;
    localparam int ASID_MSB    = 35;
    localparam int ADDR_LSB    = 11;
    localparam int ADDR_MSB    = 31;
    localparam int VALID_BIT   = 10;
    localparam int AV_BIT      = 9;
    localparam int LOCKED_BIT  = 8;
    localparam int TAG_BIT     = 7;
    localparam int WRT_BIT     = 6;
    localparam int PID_LSB     = 4;
    localparam int PID_MSB     = 5;
    localparam int PERM_LSB    = 0;
    localparam int PERM_MSB    = 3;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOCK   = 3'd1,
        ST_WBACK  = 3'd2,
        ST_FILL   = 3'd3,
        ST_UPDATE = 3'd4,
        ST_DONE   = 3'd5
    } mhu_state_t;

    // Build a descriptor; tag and wrt are always cleared by the miss handler.
    function automatic logic [DESC_W-1:0] make_desc(
        input logic [3:0]  asid,
        input logic [20:0] addr_hi,
        input logic        valid,
        input logic        av,
        input logic        locked,
        input logic [1:0]  pid,
        input logic [3:0]  perm
    );
        logic [DESC_W-1:0] d;
        d                      = '0;
        d[ASID_MSB:ASID_LSB]   = asid;
        d[ADDR_MSB:ADDR_LSB]   = addr_hi;
        d[VALID_BIT]           = valid;
        d[AV_BIT]              = av;
        d[LOCKED_BIT]          = locked;
        d[TAG_BIT]             = 1'b0;
        d[WRT_BIT]             = 1'b0;
        d[PID_MSB:PID_LSB]     = pid;
        d[PERM_MSB:PERM_LSB]   = perm;
        return d;
    endfunction

endpackage
`default_nettype wire

// File: rtl/eco32_core_lsu_dcu_victim.sv
`default_nettype none
// ============================================================================
//  Module      : eco32_core_lsu_dcu_victim
//  Description : Victim way selection (first empty way, else per-thread
//                round-robin) and the per-thread round-robin state.
//  Revision    : 1.0  initial release
// ============================================================================
module eco32_core_lsu_dcu_victim (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tid,
    input  logic [1:0] way_empty,
    input  logic       toggle,
    input  logic       toggle_tid,
    output logic       victim,
    output logic       from_rr
);

    logic [1:0] r_rr;

    // Pick an empty way if any, otherwise fall back to this thread's rr bit
    always_comb begin
        victim  = 1'b0;
        from_rr = 1'b0;
        if (way_empty[0]) begin
            victim = 1'b0;
        end else if (way_empty[1]) begin
            victim = 1'b1;
        end else begin
            victim  = r_rr[tid];
            from_rr = 1'b1;
        end
    end

    // Advance the owning thread's rr pointer once its refill completes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rr <= 2'b00;
        end else if (toggle) begin
            r_rr[toggle_tid] <= ~r_rr[toggle_tid];
        end
    end

endmodule
`default_nettype wire

// File: rtl/eco32_core_lsu_dcu_mhu.sv
`default_nettype none
// ============================================================================
//  Module      : eco32_core_lsu_dcu_mhu
//  Description : Data-cache miss handling unit. Classifies stage-b1 results
//                and runs the lock / write-back / fill / update sequence.
//  Revision    : 1.0  initial release
// ============================================================================
module eco32_core_lsu_dcu_mhu
    import eco32_core_lsu_dcu_pkg::*;
#(
    parameter int PAGE_ADDR_WIDTH = 5
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       i_stb,
    input  logic                       i_tid,
    input  logic [1:0]                 i_pid,
    input  logic [3:0]                 i_asid,
    input  logic [3:0]                 i_perm,
    input  logic [31:0]                i_v_addr,
    input  logic [1:0]                 i_way_hit,
    input  logic [1:0]                 i_way_miss,
    input  logic [1:0]                 i_way_locked,
    input  logic [1:0]                 i_way_empty,
    input  logic [1:0]                 i_way_wrt,
    input  logic [1:0]                 i_way_exc,
    input  logic [31:0]                i_way0_v_addr,
    input  logic [31:0]                i_way1_v_addr,
    output logic                       o_hit,
    output logic                       o_hit_way,
    output logic                       o_retry,
    output logic                       o_exc,
    output logic                       o_done,
    output logic                       o_busy,
    output logic                       mem_req_stb,
    output logic                       mem_req_wr,
    output logic [31:0]                mem_req_addr,
    input  logic                       mem_ack,
    output logic [1:0]                 wr_pt_stb,
    output logic                       wr_pt_tid,
    output logic [PAGE_ADDR_WIDTH-1:0] wr_pt_page,
    output logic [DESC_W-1:0]          wr_pt_descriptor
);

    localparam int LINE_W = 32 - LINE_OFS_W;

    mhu_state_t                 r_state, w_state;
    logic                       w_hit, w_hit_way, w_retry, w_exc, w_done;
    logic                       w_mem_stb, w_mem_wr;
    logic [31:0]                w_mem_addr;
    logic [1:0]                 w_pt_stb;
    logic                       w_pt_tid;
    logic [PAGE_ADDR_WIDTH-1:0] w_pt_page;
    logic [DESC_W-1:0]          w_pt_desc;

    // Captured request context
    logic [LINE_W-1:0]          r_line, w_line;
    logic [LINE_W-1:0]          r_vic_line, w_vic_line;
    logic [3:0]                 r_asid, w_asid, r_perm, w_perm;
    logic [1:0]                 r_pid, w_pid;
    logic                       r_victim, w_victim_q;
    logic                       r_dirty, w_dirty;
    logic                       r_from_rr, w_from_rr_q;

    logic                       w_victim, w_from_rr, w_toggle;
    logic                       w_unused;

    assign w_unused = ^{i_way_miss, i_v_addr[LINE_OFS_W-1:0],
                        i_way0_v_addr[LINE_OFS_W-1:0], i_way1_v_addr[LINE_OFS_W-1:0]};
    assign w_toggle = (r_state == ST_UPDATE) && r_from_rr;
    assign o_busy   = (r_state != ST_IDLE);

    eco32_core_lsu_dcu_victim u_victim (
        .clk        (clk),
        .rst_n      (rst_n),
        .tid        (i_tid),
        .way_empty  (i_way_empty),
        .toggle     (w_toggle),
        .toggle_tid (wr_pt_tid),
        .victim     (w_victim),
        .from_rr    (w_from_rr)
    );

    // Next-state and next-output logic; every registered output is computed here
    always_comb begin
        w_state     = r_state;
        w_hit       = 1'b0;
        w_hit_way   = 1'b0;
        w_retry     = 1'b0;
        w_exc       = 1'b0;
        w_done      = 1'b0;
        w_mem_stb   = mem_req_stb;
        w_mem_wr    = mem_req_wr;
        w_mem_addr  = mem_req_addr;
        w_pt_stb    = 2'b00;
        w_pt_tid    = wr_pt_tid;
        w_pt_page   = wr_pt_page;
        w_pt_desc   = wr_pt_descriptor;
        w_line      = r_line;
        w_vic_line  = r_vic_line;
        w_asid      = r_asid;
        w_perm      = r_perm;
        w_pid       = r_pid;
        w_victim_q  = r_victim;
        w_dirty     = r_dirty;
        w_from_rr_q = r_from_rr;

        if (r_state != ST_IDLE) begin
            w_retry = i_stb;
        end

        case (r_state)
            ST_IDLE: begin
                if (i_stb) begin
                    if (|i_way_exc) begin
                        w_exc = 1'b1;
                    end else if (|i_way_hit) begin
                        w_hit     = 1'b1;
                        w_hit_way = ~i_way_hit[0];
                    end else if (|i_way_locked) begin
                        w_retry = 1'b1;
                    end else begin
                        w_retry     = 1'b1;
                        w_state     = ST_LOCK;
                        w_line      = i_v_addr[31:LINE_OFS_W];
                        w_asid      = i_asid;
                        w_perm      = i_perm;
                        w_pid       = i_pid;
                        w_victim_q  = w_victim;
                        w_from_rr_q = w_from_rr;
                        w_dirty     = i_way_wrt[w_victim];
                        w_vic_line  = w_victim ? i_way1_v_addr[31:LINE_OFS_W]
                                               : i_way0_v_addr[31:LINE_OFS_W];
                        w_pt_stb    = w_victim ? 2'b10 : 2'b01;
                        w_pt_tid    = i_tid;
                        w_pt_page   = i_v_addr[PAGE_ADDR_WIDTH+LINE_OFS_W-1:LINE_OFS_W];
                        w_pt_desc   = make_desc(i_asid, i_v_addr[ADDR_MSB:ADDR_LSB],
                                                1'b1, 1'b0, 1'b1, i_pid, i_perm);
                    end
                end
            end
            ST_LOCK: begin
                w_state    = r_dirty ? ST_WBACK : ST_FILL;
                w_mem_stb  = 1'b1;
                w_mem_wr   = r_dirty;
                w_mem_addr = r_dirty ? {r_vic_line, {LINE_OFS_W{1'b0}}}
                                     : {r_line, {LINE_OFS_W{1'b0}}};
            end
            ST_WBACK: begin
                if (mem_ack) begin
                    w_state    = ST_FILL;
                    w_mem_wr   = 1'b0;
                    w_mem_addr = {r_line, {LINE_OFS_W{1'b0}}};
                end
            end
            ST_FILL: begin
                if (mem_ack) begin
                    w_state   = ST_UPDATE;
                    w_mem_stb = 1'b0;
                    w_pt_stb  = r_victim ? 2'b10 : 2'b01;
                    w_pt_desc = make_desc(r_asid, r_line[LINE_W-1:ADDR_LSB-LINE_OFS_W],
                                          1'b1, 1'b1, 1'b0, r_pid, r_perm);
                end
            end
            ST_UPDATE: begin
                w_state = ST_DONE;
                w_done  = 1'b1;
            end
            default: begin
                w_state = ST_IDLE;
            end
        endcase
    end

    // State, output and request-context registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state          <= ST_IDLE;
            o_hit            <= 1'b0;
            o_hit_way        <= 1'b0;
            o_retry          <= 1'b0;
            o_exc            <= 1'b0;
            o_done           <= 1'b0;
            mem_req_stb      <= 1'b0;
            mem_req_wr       <= 1'b0;
            mem_req_addr     <= '0;
            wr_pt_stb        <= 2'b00;
            wr_pt_tid        <= 1'b0;
            wr_pt_page       <= '0;
            wr_pt_descriptor <= '0;
            r_line           <= '0;
            r_vic_line       <= '0;
            r_asid           <= '0;
            r_perm           <= '0;
            r_pid            <= '0;
            r_victim         <= 1'b0;
            r_dirty          <= 1'b0;
            r_from_rr        <= 1'b0;
        end else begin
            r_state          <= w_state;
            o_hit            <= w_hit;
            o_hit_way        <= w_hit_way;
            o_retry          <= w_retry;
            o_exc            <= w_exc;
            o_done           <= w_done;
            mem_req_stb      <= w_mem_stb;
            mem_req_wr       <= w_mem_wr;
            mem_req_addr     <= w_mem_addr;
            wr_pt_stb        <= w_pt_stb;
            wr_pt_tid        <= w_pt_tid;
            wr_pt_page       <= w_pt_page;
            wr_pt_descriptor <= w_pt_desc;
            r_line           <= w_line;
            r_vic_line       <= w_vic_line;
            r_asid           <= w_asid;
            r_perm           <= w_perm;
            r_pid            <= w_pid;
            r_victim         <= w_victim_q;
            r_dirty          <= w_dirty;
            r_from_rr        <= w_from_rr_q;
        end
    end

endmodule
`default_nettype wire
